// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the single-cycle core.
// Produces the PC register D input every cycle, tracks the run state,
// the exception PC for a single-level trap/eret scheme and a retired count.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
  parameter int unsigned BOOT_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        trap,
  input  logic        eret,
  input  logic        halt,
  input  logic        resume,
  output logic [31:0] next_pc,
  output logic [31:0] epc,
  output logic [1:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    HANDLER = 2'd2,
    HALT    = 2'd3
  } state_t;

  // Last boot count value; the edge taken while at this value enters RUN.
  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] retired_q;
  logic        retire;

  logic [31:0] pc4, br_tgt, j_tgt, jr_tgt;

  // Candidate targets, all wrapping 32-bit arithmetic.
  assign pc4    = pc + 32'd4;
  assign br_tgt = pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign j_tgt  = {pc4[31:28], jump_index, 2'b00};
  assign jr_tgt = {jr_target[31:2], 2'b00};

  // Next-PC selection and next-state decode; fixed priority in RUN/HANDLER.
  always_comb begin
    next_pc    = pc;
    state_d    = state_q;
    epc_d      = epc_q;
    boot_cnt_d = boot_cnt_q;
    retire     = 1'b0;
    unique case (state_q)
      BOOT: begin
        // Control inputs are ignored until the boot hold expires.
        next_pc = RESET_VECTOR;
        if (boot_cnt_q == BOOT_LAST) state_d = RUN;
        else                         boot_cnt_d = boot_cnt_q + 4'd1;
      end
      HALT: begin
        // Only resume is honoured; handler context is not restored.
        if (resume) begin
          next_pc = pc4;
          state_d = RUN;
        end
      end
      default: begin
        // Traps are masked in HANDLER and eret is meaningless in RUN;
        // both fall through to the remaining priorities.
        if (trap && state_q == RUN) begin
          next_pc = TRAP_VECTOR;
          epc_d   = pc;
          state_d = HANDLER;
        end else if (eret && state_q == HANDLER) begin
          next_pc = epc_q + 32'd4;
          state_d = RUN;
          retire  = 1'b1;
        end else if (halt) begin
          state_d = HALT;
          retire  = 1'b1;
        end else if (stall) begin
          next_pc = pc;
        end else if (jr) begin
          next_pc = jr_tgt;
          retire  = 1'b1;
        end else if (jump) begin
          next_pc = j_tgt;
          retire  = 1'b1;
        end else if (branch_taken) begin
          next_pc = br_tgt;
          retire  = 1'b1;
        end else begin
          next_pc = pc4;
          retire  = 1'b1;
        end
      end
    endcase
  end

  // State, boot counter, exception PC and retired count; reset clears all.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      boot_cnt_q <= 4'd0;
      epc_q      <= 32'd0;
      retired_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      epc_q      <= epc_d;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  assign epc     = epc_q;
  assign state   = state_q;
  assign retired = retired_q;

endmodule
